// File: rtl/fc8_input_ctrl_pkg.sv
// Shared register map and CTRL bit positions for the FC8 gamepad input controller.
`timescale 1ns/1ps
package fc8_input_ctrl_pkg;

  localparam logic [2:0] FC8_INPUT_PAD1   = 3'd0;
  localparam logic [2:0] FC8_INPUT_PAD2   = 3'd1;
  localparam logic [2:0] FC8_INPUT_PRESS1 = 3'd2;
  localparam logic [2:0] FC8_INPUT_PRESS2 = 3'd3;
  localparam logic [2:0] FC8_INPUT_CTRL   = 3'd4;

  localparam int FC8_INPUT_AUTO_EN = 0;
  localparam int FC8_INPUT_IRQ_EN  = 1;
  localparam int FC8_INPUT_BUSY    = 2;
  localparam int FC8_INPUT_START   = 7;

  // START is a strobe and always reads back as 0
  function automatic logic [7:0] ctrl_rd(input logic auto_en, input logic irq_en,
                                         input logic busy);
    logic [7:0] v;
    v = 8'h00;
    v[FC8_INPUT_AUTO_EN] = auto_en;
    v[FC8_INPUT_IRQ_EN]  = irq_en;
    v[FC8_INPUT_BUSY]    = busy;
    return v;
  endfunction

endpackage

// File: rtl/fc8_input_ctrl_sync2.sv
// Two-flop synchronizer for an asynchronous 1-bit pad data line.
`timescale 1ns/1ps
module fc8_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= 2'b00;
    else     ff <= {ff[0], d};
  end

  assign q = ff[1];
endmodule

// File: rtl/fc8_input_ctrl.sv
// Two-pad serial gamepad poller: latch/clock sequencer, button/press registers,
// CPU register interface and press interrupt.
`timescale 1ns/1ps
module fc8_input_ctrl
  import fc8_input_ctrl_pkg::*;
#(
  parameter int HALF_BIT = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame_in,
  input  logic       reg_cs,
  input  logic       reg_wr_en,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_data_in,
  output logic [7:0] reg_data_out,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad1_data_n,
  input  logic       pad2_data_n,
  output logic       irq_pending_out
);

  localparam int CW = $clog2(2 * HALF_BIT);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shadow1_q, shadow2_q;
  logic [7:0]      pad1_q, pad2_q, press1_q, press2_q;
  logic            auto_en_q, irq_en_q, nf_q, irq_q;
  logic            pad_latch_q, pad_clk_q;
  logic [7:0]      rdata_q, rdata_d;
  logic            d1_s, d2_s;
  logic            wr_hit, rd_hit, start, nf_rise, trig, sample, done, busy;
  logic [7:0]      clr1, clr2, set1, set2;

  fc8_sync2 u_sync_pad1 (.clk(clk), .rst(rst), .d(pad1_data_n), .q(d1_s));
  fc8_sync2 u_sync_pad2 (.clk(clk), .rst(rst), .d(pad2_data_n), .q(d2_s));

  assign wr_hit  = reg_cs & reg_wr_en;
  assign rd_hit  = reg_cs & ~reg_wr_en;
  assign start   = wr_hit && (reg_addr == FC8_INPUT_CTRL) && reg_data_in[FC8_INPUT_START];
  assign nf_rise = new_frame_in & ~nf_q & auto_en_q;
  assign trig    = start | nf_rise;
  assign done    = (state_q == ST_DONE);
  assign busy    = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    case (state_q)
      ST_IDLE:  if (trig) state_d = ST_LATCH;
      ST_LATCH: if (cnt_q == LATCH_LAST) state_d = ST_LOW;
      ST_LOW:   if (cnt_q == HALF_LAST) begin
                  sample  = 1'b1;
                  state_d = ST_HIGH;
                end
      ST_HIGH:  if (cnt_q == HALF_LAST) state_d = (idx_q == 3'd7) ? ST_DONE : ST_LOW;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // DONE compares against the old PADn, so new presses are edges, not levels
  always_comb begin
    clr1 = (wr_hit && reg_addr == FC8_INPUT_PRESS1) ? reg_data_in : 8'h00;
    clr2 = (wr_hit && reg_addr == FC8_INPUT_PRESS2) ? reg_data_in : 8'h00;
    set1 = done ? (shadow1_q & ~pad1_q) : 8'h00;
    set2 = done ? (shadow2_q & ~pad2_q) : 8'h00;
  end

  always_comb begin
    rdata_d = 8'h00;
    case (reg_addr)
      FC8_INPUT_PAD1:   rdata_d = pad1_q;
      FC8_INPUT_PAD2:   rdata_d = pad2_q;
      FC8_INPUT_PRESS1: rdata_d = press1_q;
      FC8_INPUT_PRESS2: rdata_d = press2_q;
      FC8_INPUT_CTRL:   rdata_d = ctrl_rd(auto_en_q, irq_en_q, busy);
      default:          rdata_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shadow1_q   <= 8'h00;
      shadow2_q   <= 8'h00;
      pad1_q      <= 8'h00;
      pad2_q      <= 8'h00;
      press1_q    <= 8'h00;
      press2_q    <= 8'h00;
      auto_en_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      nf_q        <= 1'b0;
      irq_q       <= 1'b0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q || state_q == ST_IDLE) ? '0 : cnt_q + CW'(1);

      if (state_q == ST_LATCH)                         idx_q <= 3'd0;
      else if (state_q == ST_HIGH && cnt_q == HALF_LAST) idx_q <= idx_q + 3'd1;

      if (sample) begin
        shadow1_q[idx_q] <= ~d1_s;
        shadow2_q[idx_q] <= ~d2_s;
      end

      if (done) begin
        pad1_q <= shadow1_q;
        pad2_q <= shadow2_q;
      end
      press1_q <= (press1_q & ~clr1) | set1;
      press2_q <= (press2_q & ~clr2) | set2;

      if (wr_hit && reg_addr == FC8_INPUT_CTRL) begin
        auto_en_q <= reg_data_in[FC8_INPUT_AUTO_EN];
        irq_en_q  <= reg_data_in[FC8_INPUT_IRQ_EN];
      end

      nf_q  <= new_frame_in;
      irq_q <= irq_en_q & ((|press1_q) | (|press2_q));

      // Pad lines come from flops keyed on the next state so they never glitch
      pad_latch_q <= (state_d == ST_LATCH);
      pad_clk_q   <= (state_d == ST_HIGH);

      if (rd_hit) rdata_q <= rdata_d;
    end
  end

  assign reg_data_out    = rdata_q;
  assign pad_latch       = pad_latch_q;
  assign pad_clk         = pad_clk_q;
  assign irq_pending_out = irq_q;

endmodule
